// File: rtl/hdmi_island_scheduler.sv
// HDMI data-island sequencer: places preamble, guard bands and 32-cycle packet
// slots inside horizontal blanking and arbitrates four packet sources onto them.
module hdmi_island_scheduler #(
    parameter int ISLAND_START = 16,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2,
    parameter int MAX_PACKETS  = 2,
    parameter bit HSYNC_POL    = 1'b1
) (
    input  logic       i_pixclk,
    input  logic       i_rst_n,
    input  logic       i_hSync,
    input  logic       i_blank,
    input  logic [3:0] i_req,
    input  logic       i_clr_ovr,
    output logic [3:0] o_gnt,
    output logic       o_pkt_start,
    output logic [4:0] o_offset,
    output logic       o_first_pkt,
    output logic       o_preamble,
    output logic       o_guard,
    output logic       o_data,
    output logic [4:0] o_pkt_count,
    output logic       o_overrun
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(ISLAND_START - 1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(31);
    localparam logic [4:0]       MAX_CNT    = 5'(MAX_PACKETS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PREAMBLE,
        S_LGUARD,
        S_PACKET,
        S_TGUARD
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             first_q, first_d;
    logic [3:0]       wait_req_q, wait_req_d;
    logic [4:0]       pkt_count_q, pkt_count_d;
    logic             rr_q, rr_d;
    logic             overrun_q, overrun_d;
    logic             hsync_q, hsync_prev_q;

    logic             line_start;
    logic             in_island;
    logic             ovr_set;
    logic [3:0]       req_eff;
    logic [3:0]       gnt_next;

    // Fixed priority for ACR and audio sample; sources 2/3 share a round-robin
    // pointer (rr=0 favours source 2, rr=1 favours source 3).
    function automatic logic [3:0] arbitrate(input logic [3:0] req, input logic rr);
        logic [3:0] g;
        g = 4'b0000;
        if (req[0]) begin
            g = 4'b0001;
        end else if (req[1]) begin
            g = 4'b0010;
        end else if (req[2] && req[3]) begin
            g = rr ? 4'b1000 : 4'b0100;
        end else if (req[2]) begin
            g = 4'b0100;
        end else if (req[3]) begin
            g = 4'b1000;
        end
        return g;
    endfunction

    assign line_start = (hsync_q == HSYNC_POL) && (hsync_prev_q != HSYNC_POL);
    assign in_island  = (state_q != S_IDLE) && (state_q != S_WAIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        first_d     = first_q;
        wait_req_d  = wait_req_q;
        pkt_count_d = pkt_count_q;
        rr_d        = rr_q;
        ovr_set     = 1'b0;
        req_eff     = 4'b0000;
        gnt_next    = 4'b0000;

        // The count reflects every pkt_start pulse that went out, even one
        // that is immediately aborted.
        if (state_q == S_PACKET && cnt_q == '0) begin
            pkt_count_d = pkt_count_q + 5'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (line_start) begin
                    cnt_d = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d = '0;
                    if (i_blank && i_req != 4'b0000) begin
                        state_d     = S_PREAMBLE;
                        wait_req_d  = i_req;
                        pkt_count_d = 5'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_LGUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LGUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    // A request seen in WAIT stands in if the lines dropped since.
                    req_eff  = (i_req != 4'b0000) ? i_req : wait_req_q;
                    gnt_next = arbitrate(req_eff, rr_q);
                    gnt_d    = gnt_next;
                    first_d  = 1'b1;
                    state_d  = S_PACKET;
                    cnt_d    = '0;
                    if (gnt_next[2]) begin
                        rr_d = 1'b1;
                    end else if (gnt_next[3]) begin
                        rr_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PACKET: begin
                if (cnt_q == SLOT_LAST) begin
                    gnt_next = arbitrate(i_req & ~gnt_q, rr_q);
                    if (gnt_next != 4'b0000 && pkt_count_q < MAX_CNT) begin
                        gnt_d   = gnt_next;
                        first_d = 1'b0;
                        cnt_d   = '0;
                        if (gnt_next[2]) begin
                            rr_d = 1'b1;
                        end else if (gnt_next[3]) begin
                            rr_d = 1'b0;
                        end
                    end else begin
                        state_d = S_TGUARD;
                        gnt_d   = 4'b0000;
                        first_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TGUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Blanking ending mid-island overrides everything, including the pointer.
        if (in_island && !i_blank) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            gnt_d   = 4'b0000;
            first_d = 1'b0;
            rr_d    = rr_q;
            ovr_set = 1'b1;
        end

        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (i_clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            gnt_q        <= 4'b0000;
            first_q      <= 1'b0;
            wait_req_q   <= 4'b0000;
            pkt_count_q  <= 5'd0;
            rr_q         <= 1'b0;
            overrun_q    <= 1'b0;
            hsync_q      <= 1'b0;
            hsync_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            first_q      <= first_d;
            wait_req_q   <= wait_req_d;
            pkt_count_q  <= pkt_count_d;
            rr_q         <= rr_d;
            overrun_q    <= overrun_d;
            hsync_q      <= i_hSync;
            hsync_prev_q <= hsync_q;
        end
    end

    assign o_preamble  = (state_q == S_PREAMBLE);
    assign o_guard     = (state_q == S_LGUARD) || (state_q == S_TGUARD);
    assign o_data      = (state_q == S_PACKET);
    assign o_offset    = o_data ? cnt_q[4:0] : 5'd0;
    assign o_pkt_start = o_data && (cnt_q == '0);
    assign o_gnt       = o_data ? gnt_q : 4'b0000;
    assign o_first_pkt = o_data && first_q;
    assign o_pkt_count = pkt_count_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// Randomised scoreboard bench for hdmi_island_scheduler: a per-line transaction
// model predicts grants, slot timing, counts and overrun; a monitor compares.
module tb_hdmi_island_scheduler;

   localparam int ISLAND_START = 16;
   localparam int PREAMBLE_LEN = 8;
   localparam int GUARD_LEN    = 2;
   localparam int MAX_PACKETS  = 2;
   localparam int ISLAND_AT    = ISLAND_START + 2;
   localparam int SLOT0_AT     = PREAMBLE_LEN + GUARD_LEN;
   localparam int OVERHEAD     = PREAMBLE_LEN + 2 * GUARD_LEN;
   localparam int LINE_LEN     = 140;
   localparam int BLANK_END    = 120;

   logic       i_pixclk = 1'b0;
   logic       i_rst_n;
   logic       i_hSync;
   logic       i_blank;
   logic [3:0] i_req;
   logic       i_clr_ovr;
   logic [3:0] o_gnt;
   logic       o_pkt_start;
   logic [4:0] o_offset;
   logic       o_first_pkt;
   logic       o_preamble;
   logic       o_guard;
   logic       o_data;
   logic [4:0] o_pkt_count;
   logic       o_overrun;

   hdmi_island_scheduler #(
      .ISLAND_START(ISLAND_START),
      .PREAMBLE_LEN(PREAMBLE_LEN),
      .GUARD_LEN   (GUARD_LEN),
      .MAX_PACKETS (MAX_PACKETS),
      .HSYNC_POL   (1'b1)
   ) dut (
      .i_pixclk   (i_pixclk),
      .i_rst_n    (i_rst_n),
      .i_hSync    (i_hSync),
      .i_blank    (i_blank),
      .i_req      (i_req),
      .i_clr_ovr  (i_clr_ovr),
      .o_gnt      (o_gnt),
      .o_pkt_start(o_pkt_start),
      .o_offset   (o_offset),
      .o_first_pkt(o_first_pkt),
      .o_preamble (o_preamble),
      .o_guard    (o_guard),
      .o_data     (o_data),
      .o_pkt_count(o_pkt_count),
      .o_overrun  (o_overrun)
   );

   // Free-running clock and cycle counter shared by driver and monitor
   always #5 i_pixclk = ~i_pixclk;

   int unsigned cyc = 0;
   always @(posedge i_pixclk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  gnt;
      logic        first;
      logic [4:0]  count;
   } ack_t;

   typedef enum int {K_MARK, K_END, K_QUIET, K_OVR, K_RESET} kind_t;

   typedef struct {
      int unsigned cyc;
      kind_t       kind;
      logic [4:0]  count;
      logic        ovr;
      bit          chk_cnts;
      int          pre;
      int          grd;
      int          dat;
   } stat_t;

   ack_t  ack_q[$];
   stat_t stat_q[$];

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   logic [3:0] req_r;
   logic [3:0] m_pend;
   int         m_ptr;
   logic [4:0] m_count;
   logic       m_ovr;

   // Compare one observed value against the model's expectation
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   // Higher-level arbitration rule: ACR, then audio sample, then 2/3 by pointer
   function automatic int pickSource(input logic [3:0] pend, input int ptr);
      if (pend[0]) return 0;
      if (pend[1]) return 1;
      if (pend[2] && pend[3]) return ptr;
      if (pend[2]) return 2;
      return 3;
   endfunction

   task automatic pushStat(input int unsigned c, input kind_t k, input logic [4:0] cnt,
                           input logic ovr, input bit chk, input int pre, input int grd, input int dat);
      stat_t s;
      s.cyc = c; s.kind = k; s.count = cnt; s.ovr = ovr;
      s.chk_cnts = chk; s.pre = pre; s.grd = grd; s.dat = dat;
      stat_q.push_back(s);
   endtask

   // Advance to the next falling edge; requesters drop a line once acked
   task automatic stepCycle();
      @(negedge i_pixclk);
      if (o_pkt_start) req_r = req_r & ~o_gnt;
      i_req = req_r;
   endtask

   // One video line: model predicts the island, then the inputs are driven
   task automatic applyStimulus(input logic [3:0] new_req, input bit blank_ok,
                                input int abort_c, input bit clr);
      int unsigned base;
      logic [3:0]  pend;
      int          order[$];
      int          tmp_ptr;
      int          k_full;
      int          started;
      int          src;
      bit          island;
      bit          aborted;
      ack_t        a;

      base   = cyc;
      req_r  = req_r | new_req;
      i_req  = req_r;
      m_pend = m_pend | new_req;

      pend    = m_pend;
      island  = blank_ok && (pend != 4'b0000);
      tmp_ptr = m_ptr;
      while (island && pend != 4'b0000 && order.size() < MAX_PACKETS) begin
         src = pickSource(pend, tmp_ptr);
         order.push_back(src);
         if (src == 2) tmp_ptr = 3;
         else if (src == 3) tmp_ptr = 2;
         pend[src] = 1'b0;
      end
      k_full  = order.size();
      aborted = island && abort_c >= 0 && abort_c < OVERHEAD + 32 * k_full;

      started = 0;
      foreach (order[j]) begin
         if (!aborted || SLOT0_AT + 32 * j <= abort_c) begin
            a.cyc   = base + ISLAND_AT + SLOT0_AT + 32 * j;
            a.gnt   = 4'(1 << order[j]);
            a.first = (j == 0);
            a.count = 5'(j);
            ack_q.push_back(a);
            if (order[j] == 2) m_ptr = 3;
            else if (order[j] == 3) m_ptr = 2;
            m_pend[order[j]] = 1'b0;
            started++;
         end
      end
      if (island) m_count = 5'(started);
      if (aborted) m_ovr = 1'b1;

      pushStat(base + 1, K_MARK, 5'd0, 1'b0, 1'b0, 0, 0, 0);
      if (aborted) pushStat(base + ISLAND_AT + 1 + abort_c, K_QUIET, 5'd0, 1'b1, 1'b0, 0, 0, 0);
      pushStat(base + 130, K_END, m_count, m_ovr, !aborted,
               island ? PREAMBLE_LEN : 0, island ? 2 * GUARD_LEN : 0, 32 * k_full);
      if (clr) begin
         m_ovr = 1'b0;
         pushStat(base + 134, K_OVR, 5'd0, 1'b0, 1'b0, 0, 0, 0);
      end

      i_hSync   = 1'b1;
      i_blank   = blank_ok;
      i_clr_ovr = 1'b0;
      for (int n = 1; n < LINE_LEN; n++) begin
         stepCycle();
         if (n == 4) i_hSync = 1'b0;
         if (abort_c >= 0 && n == ISLAND_AT + abort_c) i_blank = 1'b0;
         if (n == BLANK_END) i_blank = 1'b0;
         if (clr && n == 132) i_clr_ovr = 1'b1;
         if (n == 133) i_clr_ovr = 1'b0;
      end
   endtask

   // Driver: reset checks, directed lines, then randomised lines
   initial begin
      int unsigned base;
      logic [3:0]  nr;
      bit          bo;
      int          ab;
      bit          cl;

      i_rst_n = 1'b0; i_hSync = 1'b0; i_blank = 1'b0; i_req = 4'b0000; i_clr_ovr = 1'b0;
      req_r = 4'b0000; m_pend = 4'b0000; m_ptr = 2; m_count = 5'd0; m_ovr = 1'b0;
      repeat (3) @(negedge i_pixclk);
      pushStat(cyc + 1, K_RESET, 5'd0, 1'b0, 1'b0, 0, 0, 0);
      stepCycle();
      stepCycle();
      i_rst_n = 1'b1;
      stepCycle();

      // Reset asserted at slot offset 10 of a single-packet island
      $display("[TB] reset during packet slot");
      base = cyc;
      req_r = 4'b0001; i_req = req_r; i_hSync = 1'b1; i_blank = 1'b1;
      ack_q.push_back('{base + ISLAND_AT + SLOT0_AT, 4'b0001, 1'b1, 5'd0});
      for (int n = 1; n < ISLAND_AT + SLOT0_AT + 10; n++) begin
         stepCycle();
         if (n == 4) i_hSync = 1'b0;
      end
      @(posedge i_pixclk);
      #1 i_rst_n = 1'b0;
      pushStat(base + ISLAND_AT + SLOT0_AT + 10, K_RESET, 5'd0, 1'b0, 1'b0, 0, 0, 0);
      repeat (3) stepCycle();
      i_rst_n = 1'b1;
      m_pend = 4'b0000; m_ptr = 2; m_count = 5'd0; m_ovr = 1'b0;
      pushStat(cyc + 2, K_MARK, 5'd0, 1'b0, 1'b0, 0, 0, 0);
      pushStat(cyc + 60, K_END, 5'd0, 1'b0, 1'b1, 0, 0, 0);
      repeat (65) stepCycle();

      $display("[TB] directed lines");
      applyStimulus(4'b0001, 1'b1, -1, 1'b0);
      applyStimulus(4'b1111, 1'b1, -1, 1'b0);
      applyStimulus(4'b0000, 1'b1, -1, 1'b0);
      applyStimulus(4'b0110, 1'b1, -1, 1'b0);
      applyStimulus(4'b1100, 1'b1, -1, 1'b0);
      applyStimulus(4'b0001, 1'b1, SLOT0_AT + 5, 1'b1);
      applyStimulus(4'b0000, 1'b1, -1, 1'b0);
      applyStimulus(4'b0010, 1'b0, -1, 1'b0);

      $display("[TB] random lines");
      for (int i = 0; i < 30; i++) begin
         nr = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         bo = ($urandom_range(0, 9) != 0);
         ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 80)) : -1;
         cl = ($urandom_range(0, 2) == 0);
         applyStimulus(nr, bo, ab, cl);
      end

      done = 1'b1;
      repeat (10) @(negedge i_pixclk);
   end

   // Monitor: pops expected acks on pkt_start and scheduled status checks
   initial begin
      int   tot_pre = 0, tot_grd = 0, tot_dat = 0;
      int   snap_pre = 0, snap_grd = 0, snap_dat = 0;
      ack_t a;
      stat_t s;
      forever begin
         @(negedge i_pixclk);
         tot_pre += int'(o_preamble);
         tot_grd += int'(o_guard);
         tot_dat += int'(o_data);

         if (o_pkt_start) begin
            if (ack_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_ack at cycle %0d: got gnt %b, expected no packet", cyc, o_gnt);
            end else begin
               a = ack_q.pop_front();
               checkOutput("ack_cycle", int'(cyc), int'(a.cyc));
               checkOutput("ack_gnt", int'(o_gnt), int'(a.gnt));
               checkOutput("ack_first_pkt", int'(o_first_pkt), int'(a.first));
               checkOutput("ack_pkt_count", int'(o_pkt_count), int'(a.count));
               checkOutput("ack_offset", int'(o_offset), 0);
            end
         end
         while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
            a = ack_q.pop_front();
            checkOutput("missing_ack_cycle", int'(cyc), int'(a.cyc));
         end

         while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
            s = stat_q.pop_front();
            case (s.kind)
               K_MARK: begin
                  snap_pre = tot_pre; snap_grd = tot_grd; snap_dat = tot_dat;
               end
               K_END: begin
                  checkOutput("line_pkt_count", int'(o_pkt_count), int'(s.count));
                  checkOutput("line_overrun", int'(o_overrun), int'(s.ovr));
                  if (s.chk_cnts) begin
                     checkOutput("preamble_cycles", tot_pre - snap_pre, s.pre);
                     checkOutput("guard_cycles", tot_grd - snap_grd, s.grd);
                     checkOutput("data_cycles", tot_dat - snap_dat, s.dat);
                  end
               end
               K_QUIET: begin
                  checkOutput("abort_strobes", int'({o_preamble, o_guard, o_data, o_pkt_start, o_first_pkt}), 0);
                  checkOutput("abort_gnt", int'(o_gnt), 0);
                  checkOutput("abort_offset", int'(o_offset), 0);
                  checkOutput("abort_overrun", int'(o_overrun), int'(s.ovr));
               end
               K_OVR: begin
                  checkOutput("clr_overrun", int'(o_overrun), int'(s.ovr));
               end
               default: begin
                  checkOutput("reset_strobes", int'({o_preamble, o_guard, o_data, o_pkt_start, o_first_pkt}), 0);
                  checkOutput("reset_gnt", int'(o_gnt), 0);
                  checkOutput("reset_offset", int'(o_offset), 0);
                  checkOutput("reset_pkt_count", int'(o_pkt_count), 0);
                  checkOutput("reset_overrun", int'(o_overrun), 0);
               end
            endcase
         end

         if (done) begin
            checkOutput("acks_outstanding", ack_q.size(), 0);
            checkOutput("status_outstanding", stat_q.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog at cycle %0d: got no completion, expected finish", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
